// File: rtl/div_seq_param.sv
// Sequential restoring divider: one quotient bit per cycle on operand magnitudes,
// with signed/unsigned modes, divide-by-zero and signed-overflow flags.
module div_seq_param #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    input  logic          signed_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero,
    output logic          ovf
);

    localparam int CW = (DW > 2) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_q;
    logic [VW-1:0] r_rem;
    logic [VW-1:0] r_dvs;
    logic [CW-1:0] r_cnt;
    logic          r_neg_q, r_neg_r, r_ovf;
    logic [DW-1:0] r_quot;
    logic [VW-1:0] r_remo;
    logic          r_dbz, r_ovf_o;

    logic          w_accept, w_dd_neg, w_dv_neg, w_dv_zero, w_ovf;
    logic [DW-1:0] w_dd_mag;
    logic [VW-1:0] w_dv_mag;
    logic [VW:0]   w_part;
    logic          w_ge, w_last;
    logic [VW-1:0] w_rem_nxt, w_r_res;
    logic [DW-1:0] w_q_nxt, w_q_res;

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_dd_neg  = signed_mode & dividend[DW-1];
    assign w_dv_neg  = signed_mode & divisor[VW-1];
    // Magnitudes are held unsigned, so -2^(N-1) maps to 2^(N-1) without loss
    assign w_dd_mag  = w_dd_neg ? -dividend : dividend;
    assign w_dv_mag  = w_dv_neg ? -divisor : divisor;
    assign w_dv_zero = (divisor == '0);
    assign w_ovf     = signed_mode && (dividend == {1'b1, {(DW-1){1'b0}}}) && (divisor == '1);

    // Dividend bits shift out of r_q MSB-first while quotient bits shift in at the LSB
    assign w_part    = {r_rem, r_q[DW-1]};
    assign w_ge      = (w_part >= {1'b0, r_dvs});
    assign w_rem_nxt = w_ge ? VW'(w_part - {1'b0, r_dvs}) : w_part[VW-1:0];
    assign w_q_nxt   = {r_q[DW-2:0], w_ge};
    assign w_last    = (r_cnt == CW'(DW-1));
    assign w_q_res   = r_neg_q ? -w_q_nxt : w_q_nxt;
    assign w_r_res   = r_neg_r ? -w_rem_nxt : w_rem_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = w_dv_zero ? DONE : BUSY;
            BUSY:    if (w_last) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_ovf   <= 1'b0;
            r_quot  <= '0;
            r_remo  <= '0;
            r_dbz   <= 1'b0;
            r_ovf_o <= 1'b0;
        end else if (w_accept) begin
            r_q     <= w_dd_mag;
            r_rem   <= '0;
            r_dvs   <= w_dv_mag;
            r_cnt   <= '0;
            r_neg_q <= w_dd_neg ^ w_dv_neg;
            r_neg_r <= w_dd_neg;
            r_ovf   <= w_ovf;
            if (w_dv_zero) begin
                r_quot  <= '1;
                r_remo  <= '0;
                r_dbz   <= 1'b1;
                r_ovf_o <= 1'b0;
            end
        end else if (r_state == BUSY) begin
            r_q   <= w_q_nxt;
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_quot  <= w_q_res;
                r_remo  <= w_r_res;
                r_dbz   <= 1'b0;
                r_ovf_o <= r_ovf;
            end
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign quotient    = r_quot;
    assign remainder   = r_remo;
    assign div_by_zero = r_dbz;
    assign ovf         = r_ovf_o;

endmodule

// File: tb/tb_div_seq_param.sv
// Directed bench for div_seq_param (DW=16, VW=8): hand-computed vectors,
// latency, backpressure and reset-abort scenarios.
module tb_div_seq_param;

    localparam int DW = 16;
    localparam int VW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          signed_mode = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
    logic          ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_seq_param #(.DW(DW), .VW(VW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .signed_mode(signed_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .ovf(ovf)
    );

    // Accepts one operation, scrambles the inputs afterwards, and returns the number
    // of edges after the accept edge at which out_valid was first seen (100 = timeout).
    task automatic run_op(input logic [DW-1:0] dd, input logic [VW-1:0] dv,
                          input logic sm, output int lat);
        dividend    = dd;
        divisor     = dv;
        signed_mode = sm;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        dividend    = 16'hA5C3;
        divisor     = 8'h3C;
        signed_mode = ~sm;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({out_valid, quotient, remainder, div_by_zero, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ov=%b q=%h r=%h dbz=%b ovf=%b, want all 0",
                     out_valid, quotient, remainder, div_by_zero, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_unsigned();
        int lat;
        logic [DW-1:0] eq [3];
        logic [VW-1:0] er [3];
        logic [DW-1:0] dd [3];
        logic [VW-1:0] dv [3];
        dd = '{16'd1000, 16'hFFFF, 16'd100};
        dv = '{8'd7,     8'hFF,    8'd200};
        eq = '{16'd142,  16'd257,  16'd0};
        er = '{8'd6,     8'd0,     8'd100};
        for (int i = 0; i < 3; i++) begin
            run_op(dd[i], dv[i], 1'b0, lat);
            checks++;
            if (lat !== 16) begin
                errors++;
                $display("FAIL unsigned_latency[%0d]: got %0d edges want 16", i, lat);
            end
            checks++;
            if ({quotient, remainder, div_by_zero, ovf} !== {eq[i], er[i], 2'b00}) begin
                errors++;
                $display("FAIL unsigned_result[%0d]: got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=0 ovf=0",
                         i, quotient, remainder, div_by_zero, ovf, eq[i], er[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_signed();
        int lat;
        logic [DW-1:0] eq [4];
        logic [VW-1:0] er [4];
        logic [DW-1:0] dd [4];
        logic [VW-1:0] dv [4];
        // -1000/7, 1000/-7, -32768/-128, -7/-2
        dd = '{16'hFC18, 16'd1000, 16'h8000, 16'hFFF9};
        dv = '{8'd7,     8'hF9,    8'h80,    8'hFE};
        eq = '{16'hFF72, 16'hFF72, 16'h0100, 16'h0003};
        er = '{8'hFA,    8'h06,    8'h00,    8'hFF};
        for (int i = 0; i < 4; i++) begin
            run_op(dd[i], dv[i], 1'b1, lat);
            checks++;
            if (lat !== 16 ||
                {quotient, remainder, div_by_zero, ovf} !== {eq[i], er[i], 2'b00}) begin
                errors++;
                $display("FAIL signed_result[%0d]: got lat=%0d q=%h r=%h dbz=%b ovf=%b want lat=16 q=%h r=%h dbz=0 ovf=0",
                         i, lat, quotient, remainder, div_by_zero, ovf, eq[i], er[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div_zero();
        int lat;
        run_op(16'h1234, 8'h00, 1'b0, lat);
        checks++;
        if (lat !== 0) begin
            errors++;
            $display("FAIL dbz_latency: out_valid seen %0d edges after accept edge, want 0 (DONE on accept)", lat);
        end
        checks++;
        if ({quotient, remainder, div_by_zero, ovf} !== {16'hFFFF, 8'h00, 2'b10}) begin
            errors++;
            $display("FAIL dbz_result: got q=%h r=%h dbz=%b ovf=%b want q=ffff r=00 dbz=1 ovf=0",
                     quotient, remainder, div_by_zero, ovf);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ovf();
        int lat;
        run_op(16'h8000, 8'hFF, 1'b1, lat);
        checks++;
        if (lat !== 16 || {quotient, remainder, div_by_zero, ovf} !== {16'h8000, 8'h00, 2'b01}) begin
            errors++;
            $display("FAIL ovf_result: got lat=%0d q=%h r=%h dbz=%b ovf=%b want lat=16 q=8000 r=00 dbz=0 ovf=1",
                     lat, quotient, remainder, div_by_zero, ovf);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        run_op(16'd1000, 8'd7, 1'b0, lat);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            dividend = 16'd50;
            divisor  = 8'd5;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {quotient, remainder, div_by_zero, ovf} !== {16'd142, 8'd6, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got ov=%b ir=%b q=%h r=%h want ov=1 ir=0 q=008e r=06",
                         c, out_valid, in_ready, quotient, remainder);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 16'd142 || remainder !== 8'd6) begin
            errors++;
            $display("FAIL bp_release: got ov=%b ir=%b q=%h r=%h want ov=0 ir=1 q=008e r=06",
                     out_valid, in_ready, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(16'd50, 8'd5, 1'b0, lat);
        @(posedge clk); #1;
        // Next accept immediately in the cycle after the handshake
        run_op(16'd255, 8'd16, 1'b0, lat);
        checks++;
        if (lat !== 16 || quotient !== 16'd15 || remainder !== 8'd15) begin
            errors++;
            $display("FAIL back_to_back: got lat=%0d q=%h r=%h want lat=16 q=000f r=0f",
                     lat, quotient, remainder);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int seen;
        dividend    = 16'd1000;
        divisor     = 8'd7;
        signed_mode = 1'b0;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, quotient, remainder, div_by_zero, ovf} !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_reset: got ov=%b ir=%b q=%h r=%h dbz=%b ovf=%b want ov=0 ir=1 rest 0",
                     out_valid, in_ready, quotient, remainder, div_by_zero, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_result: out_valid/!in_ready seen %0d cycles after release, want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_ovf();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
